// File: rtl/ram_host_bridge.sv
// Byte-stream WRITE/READ command front-end for the register-file RAM (single-cycle writes, one-cycle registered reads).
// Optional build macro RAM_HOST_BRIDGE_AUTOINC_EN: post-increment address plus opcodes 0x11/0x12 that reuse it.
module ram_host_bridge #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_valid_i,
  output logic                     rx_ready_o,
  output logic [7:0]               tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  output logic [ADDRESS_WIDTH-1:0] ram_address_o,
  output logic [DATA_WIDTH-1:0]    ram_data_o,
  output logic                     ram_we_o,
  input  logic [DATA_WIDTH-1:0]    ram_data_i,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
`ifdef RAM_HOST_BRIDGE_AUTOINC_EN
  localparam logic [7:0] OP_WRITE_INC = 8'h11;
  localparam logic [7:0] OP_READ_INC  = 8'h12;
`endif

  if (ADDRESS_WIDTH < 1 || ADDRESS_WIDTH > 8) begin : g_bad_address_width
    $error("ram_host_bridge: ADDRESS_WIDTH must be 1..8");
  end
  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("ram_host_bridge: DATA_WIDTH must be a non-zero multiple of 8");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WRITE,
    S_RD_ISSUE,
    S_RD_CAPTURE,
    S_TX
  } state_e;

  state_e                   state_q;
  logic                     op_write_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [CW-1:0]            cnt_q;
  logic [DATA_WIDTH-1:0]    word_q;
  logic [DATA_WIDTH-1:0]    tx_shift_q;
  logic                     tx_valid_q;
  logic                     rx_ready_q;
  logic [ADDRESS_WIDTH-1:0] ram_address_q;
  logic [DATA_WIDTH-1:0]    ram_data_q;
  logic                     ram_we_q;
  logic                     err_q;

  logic                     rx_fire;
  logic                     tx_fire;
  logic [DATA_WIDTH-1:0]    word_next;
  logic [ADDRESS_WIDTH-1:0] rx_addr;

  assign rx_fire   = rx_valid_i && rx_ready_q;
  assign tx_fire   = tx_valid_q && tx_ready_i;
  assign word_next = (word_q << 8) | DATA_WIDTH'(rx_data_i);
  assign rx_addr   = rx_data_i[ADDRESS_WIDTH-1:0];

  // NOTE: rx_ready is a flop that resets to 0, so it reads low during reset and rises on the first edge after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      op_write_q    <= 1'b0;
      addr_q        <= '0;
      cnt_q         <= '0;
      word_q        <= '0;
      tx_shift_q    <= '0;
      tx_valid_q    <= 1'b0;
      rx_ready_q    <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_we_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // NOTE: pulse outputs get a non-blocking default here; a later assignment in the same pass wins.
      ram_we_q <= 1'b0;
      err_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          rx_ready_q <= 1'b1;
          if (rx_fire) begin
            case (rx_data_i)
              OP_WRITE, OP_READ: begin
                op_write_q <= (rx_data_i == OP_WRITE);
                state_q    <= S_ADDR;
              end
`ifdef RAM_HOST_BRIDGE_AUTOINC_EN
              OP_WRITE_INC: begin
                cnt_q   <= '0;
                state_q <= S_WDATA;
              end
              OP_READ_INC: begin
                ram_address_q <= addr_q;
                rx_ready_q    <= 1'b0;
                state_q       <= S_RD_ISSUE;
              end
`endif
              default: err_q <= 1'b1;
            endcase
          end
        end

        S_ADDR: begin
          if (rx_fire) begin
            addr_q <= rx_addr;
            if (op_write_q) begin
              cnt_q   <= '0;
              state_q <= S_WDATA;
            end else begin
              ram_address_q <= rx_addr;
              rx_ready_q    <= 1'b0;
              state_q       <= S_RD_ISSUE;
            end
          end
        end

        S_WDATA: begin
          if (rx_fire) begin
            word_q <= word_next;
            if (cnt_q == LAST_BYTE) begin
              ram_address_q <= addr_q;
              ram_data_q    <= word_next;
              ram_we_q      <= 1'b1;
              rx_ready_q    <= 1'b0;
              state_q       <= S_WRITE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end

        S_WRITE: begin
`ifdef RAM_HOST_BRIDGE_AUTOINC_EN
          addr_q <= addr_q + ADDRESS_WIDTH'(1);
`endif
          rx_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end

        // The RAM registers its read word on the edge that leaves this state.
        S_RD_ISSUE: state_q <= S_RD_CAPTURE;

        S_RD_CAPTURE: begin
`ifdef RAM_HOST_BRIDGE_AUTOINC_EN
          addr_q <= addr_q + ADDRESS_WIDTH'(1);
`endif
          tx_shift_q <= ram_data_i;
          tx_valid_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= S_TX;
        end

        S_TX: begin
          if (tx_fire) begin
            tx_shift_q <= tx_shift_q << 8;
            if (cnt_q == LAST_BYTE) begin
              tx_valid_q <= 1'b0;
              rx_ready_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end

        default: begin
          tx_valid_q <= 1'b0;
          rx_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_ready_o    = rx_ready_q;
  assign tx_data_o     = tx_shift_q[DATA_WIDTH-1 -: 8];
  assign tx_valid_o    = tx_valid_q;
  assign ram_address_o = ram_address_q;
  assign ram_data_o    = ram_data_q;
  assign ram_we_o      = ram_we_q;
  assign busy_o        = (state_q != S_IDLE);
  assign err_o         = err_q;

endmodule

// File: tb/tb_ram_host_bridge.sv
// Directed bench for ram_host_bridge with a behavioural registered-read RAM attached to its RAM pins.
module tb_ram_host_bridge;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk_i    = 1'b0;
  logic          rst_ni   = 1'b1;
  logic [7:0]    rx_data  = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready_o;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready = 1'b1;
  logic [AW-1:0] ram_address_o;
  logic [DW-1:0] ram_data_o;
  logic          ram_we_o;
  logic [DW-1:0] ram_rdata;
  logic          busy_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  int            we_count = 0;
  int            we_long = 0;
  int            we_cyc = 0;
  logic [AW-1:0] we_addr = '0;
  logic [DW-1:0] we_data = '0;
  int            err_count = 0;
  int            err_long = 0;
  int            err_cyc = 0;
  logic          prev_we = 1'b0;
  logic          prev_err = 1'b0;

  logic [DW-1:0] mem [2**AW];

  ram_host_bridge #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rx_data_i     (rx_data),
    .rx_valid_i    (rx_valid),
    .rx_ready_o    (rx_ready_o),
    .tx_data_o     (tx_data_o),
    .tx_valid_o    (tx_valid_o),
    .tx_ready_i    (tx_ready),
    .ram_address_o (ram_address_o),
    .ram_data_o    (ram_data_o),
    .ram_we_o      (ram_we_o),
    .ram_data_i    (ram_rdata),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    if (ram_we_o) mem[ram_address_o] <= ram_data_o;
    ram_rdata <= mem[ram_address_o];
  end

  // cyc read at the falling edge equals the index of the rising edge just before it.
  always @(negedge clk_i) begin
    if (ram_we_o) begin
      we_count++;
      we_cyc  = cyc;
      we_addr = ram_address_o;
      we_data = ram_data_o;
      if (prev_we) we_long++;
    end
    if (err_o) begin
      err_count++;
      err_cyc = cyc;
      if (prev_err) err_long++;
    end
    prev_we  = ram_we_o;
    prev_err = err_o;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!rx_ready_o) begin
      $display("FAIL rx_handshake_timeout: rx_ready_o=%b required 1 (byte %02h)", rx_ready_o, b);
      checks++;
      errors++;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    last_acc = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic collect_word(output logic [31:0] w, output int lat);
    int n;
    w = '0;
    n = 0;
    while (!tx_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    lat = cyc - last_acc;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!tx_valid_o && n < 20) begin
        @(negedge clk_i);
        n++;
      end
      if (!tx_valid_o) begin
        $display("FAIL tx_byte_timeout: tx_valid_o=%b required 1 (byte %0d)", tx_valid_o, i);
        checks++;
        errors++;
      end
      w = {w[23:0], tx_data_o};
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    idle(2);
    checks++;
    if ({rx_ready_o, tx_valid_o, tx_data_o, ram_we_o, busy_o, err_o} !== 13'h0) begin
      $display("FAIL reset_ctrl: rdy=%b tv=%b td=%02h we=%b busy=%b err=%b required all 0",
               rx_ready_o, tx_valid_o, tx_data_o, ram_we_o, busy_o, err_o);
      errors++;
    end
    checks++;
    if (ram_address_o !== '0 || ram_data_o !== '0) begin
      $display("FAIL reset_ram_bus: addr=%0d data=%08h required 0/00000000", ram_address_o, ram_data_o);
      errors++;
    end
    rst_ni = 1'b1;
    idle(1);
    checks++;
    if (rx_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      $display("FAIL reset_release: rx_ready_o=%b busy_o=%b required 1/0", rx_ready_o, busy_o);
      errors++;
    end
  endtask

  task automatic test_write_read();
    int   base_we = we_count;
    int   lat;
    logic [31:0] w;
    send_byte(8'h01);
    send_byte(8'h03);
    send_word(32'hDEADBEEF);
    idle(3);
    checks++;
    if (we_count - base_we !== 1 || we_long !== 0) begin
      $display("FAIL write_pulse: pulses=%0d long=%0d required 1/0", we_count - base_we, we_long);
      errors++;
    end
    checks++;
    if (we_addr !== 5'd3 || we_data !== 32'hDEADBEEF) begin
      $display("FAIL write_bus: addr=%0d data=%08h required 3/deadbeef", we_addr, we_data);
      errors++;
    end
    // Write strobe belongs in the cycle right after the last data byte's edge.
    checks++;
    if (we_cyc - last_acc !== 0) begin
      $display("FAIL write_latency: offset=%0d required 0", we_cyc - last_acc);
      errors++;
    end
    send_byte(8'h02);
    send_byte(8'h03);
    collect_word(w, lat);
    checks++;
    if (w !== 32'hDEADBEEF) begin
      $display("FAIL read_data: got=%08h required deadbeef", w);
      errors++;
    end
    // Address byte at edge N, first tx_valid in cycle N+3 (seen after edge N+2).
    checks++;
    if (lat !== 2) begin
      $display("FAIL read_latency: offset=%0d required 2", lat);
      errors++;
    end
    checks++;
    if (tx_valid_o !== 1'b0 || busy_o !== 1'b0 || rx_ready_o !== 1'b1) begin
      $display("FAIL read_done: tv=%b busy=%b rdy=%b required 0/0/1", tx_valid_o, busy_o, rx_ready_o);
      errors++;
    end
  endtask

  task automatic test_addr_mask();
    int   lat;
    logic [31:0] w;
    send_byte(8'h01);
    send_byte(8'hE7);
    send_word(32'h0000005A);
    idle(3);
    checks++;
    if (we_addr !== 5'd7 || we_data !== 32'h0000005A) begin
      $display("FAIL mask_write: addr=%0d data=%08h required 7/0000005a", we_addr, we_data);
      errors++;
    end
    send_byte(8'h02);
    send_byte(8'h07);
    collect_word(w, lat);
    checks++;
    if (w !== 32'h0000005A) begin
      $display("FAIL mask_read: got=%08h required 0000005a", w);
      errors++;
    end
  endtask

  task automatic test_backpressure();
    int   n = 0;
    int   bad = 0;
    int   lat;
    logic [31:0] w;
    tx_ready = 1'b0;
    send_byte(8'h02);
    send_byte(8'h03);
    while (!tx_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    repeat (10) begin
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hDE || rx_ready_o !== 1'b0 || busy_o !== 1'b1) bad++;
      @(negedge clk_i);
    end
    checks++;
    if (bad !== 0) begin
      $display("FAIL bp_hold: bad_cycles=%0d (tv=%b td=%02h rdy=%b busy=%b) required 0 (1/de/0/1)",
               bad, tx_valid_o, tx_data_o, rx_ready_o, busy_o);
      errors++;
    end
    tx_ready = 1'b1;
    collect_word(w, lat);
    checks++;
    if (w !== 32'hDEADBEEF) begin
      $display("FAIL bp_data: got=%08h required deadbeef", w);
      errors++;
    end
    checks++;
    if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL bp_done: tv=%b busy=%b required 0/0", tx_valid_o, busy_o);
      errors++;
    end
  endtask

  task automatic test_unknown_opcode();
    int   base_we = we_count;
    int   base_err = err_count;
    int   acc;
    int   lat;
    logic [31:0] w;
    send_byte(8'h7F);
    acc = last_acc;
    idle(3);
    checks++;
    if (err_count - base_err !== 1 || err_long !== 0 || err_cyc - acc !== 0) begin
      $display("FAIL err_pulse: pulses=%0d long=%0d offset=%0d required 1/0/0",
               err_count - base_err, err_long, err_cyc - acc);
      errors++;
    end
    checks++;
    if (we_count !== base_we || busy_o !== 1'b0) begin
      $display("FAIL err_side_effect: we_pulses=%0d busy=%b required %0d/0", we_count, busy_o, base_we);
      errors++;
    end
    send_byte(8'h02);
    send_byte(8'h00);
    collect_word(w, lat);
    checks++;
    if (w !== 32'h10000000) begin
      $display("FAIL err_recover_read: got=%08h required 10000000", w);
      errors++;
    end
  endtask

  task automatic test_reset_mid_write();
    int   base_we = we_count;
    int   lat;
    logic [31:0] w;
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    checks++;
    if (busy_o !== 1'b1 || rx_ready_o !== 1'b1) begin
      $display("FAIL midwrite_state: busy=%b rdy=%b required 1/1", busy_o, rx_ready_o);
      errors++;
    end
    rst_ni = 1'b0;
    idle(1);
    checks++;
    if ({rx_ready_o, tx_valid_o, tx_data_o, ram_we_o, busy_o, err_o} !== 13'h0 ||
        ram_address_o !== '0 || ram_data_o !== '0) begin
      $display("FAIL midwrite_reset_outs: rdy=%b tv=%b we=%b busy=%b addr=%0d data=%08h required 0/0/0/0/0/00000000",
               rx_ready_o, tx_valid_o, ram_we_o, busy_o, ram_address_o, ram_data_o);
      errors++;
    end
    idle(1);
    rst_ni = 1'b1;
    idle(3);
    checks++;
    if (we_count !== base_we) begin
      $display("FAIL midwrite_no_write: we_pulses=%0d required %0d", we_count, base_we);
      errors++;
    end
    send_byte(8'h02);
    send_byte(8'h05);
    collect_word(w, lat);
    checks++;
    if (w !== 32'h10000005) begin
      $display("FAIL midwrite_untouched: got=%08h required 10000005", w);
      errors++;
    end
    send_byte(8'h01);
    send_byte(8'h05);
    send_word(32'hCAFEF00D);
    send_byte(8'h02);
    send_byte(8'h05);
    collect_word(w, lat);
    checks++;
    if (w !== 32'hCAFEF00D) begin
      $display("FAIL midwrite_fresh_cmd: got=%08h required cafef00d", w);
      errors++;
    end
  endtask

`ifdef RAM_HOST_BRIDGE_AUTOINC_EN
  task automatic test_autoinc();
    int   lat;
    logic [31:0] w;
    send_byte(8'h01);
    send_byte(8'h1F);
    send_word(32'h11223344);
    idle(2);
    checks++;
    if (we_addr !== 5'd31 || we_data !== 32'h11223344) begin
      $display("FAIL autoinc_first: addr=%0d data=%08h required 31/11223344", we_addr, we_data);
      errors++;
    end
    send_byte(8'h11);
    send_word(32'h55667788);
    idle(2);
    checks++;
    if (we_addr !== 5'd0 || we_data !== 32'h55667788) begin
      $display("FAIL autoinc_wrap: addr=%0d data=%08h required 0/55667788", we_addr, we_data);
      errors++;
    end
    send_byte(8'h02);
    send_byte(8'h1F);
    collect_word(w, lat);
    send_byte(8'h12);
    collect_word(w, lat);
    checks++;
    if (w !== 32'h55667788 || lat !== 2) begin
      $display("FAIL autoinc_read: got=%08h lat=%0d required 55667788/2", w, lat);
      errors++;
    end
  endtask
`else
  task automatic test_autoinc();
    int base_we = we_count;
    int base_err = err_count;
    send_byte(8'h11);
    idle(3);
    checks++;
    if (err_count - base_err !== 1 || we_count !== base_we || busy_o !== 1'b0) begin
      $display("FAIL autoinc_disabled: err_pulses=%0d we_pulses=%0d busy=%b required 1/%0d/0",
               err_count - base_err, we_count, busy_o, base_we);
      errors++;
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 32'h1000_0000 + 32'(i);
    test_reset();
    test_write_read();
    test_addr_mask();
    test_backpressure();
    test_unknown_opcode();
    test_reset_mid_write();
    test_autoinc();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_host_bridge.md
Name: ram_host_bridge

Overview:
Byte-stream command front-end that sits directly upstream of the register-file RAM and drives its address, data and write-enable pins. Accepts WRITE and READ commands as a valid/ready byte stream, assembles DATA_WIDTH-bit words and issues single-cycle RAM writes. Handles the RAM's one-cycle registered read and serialises read data back out on a valid/ready byte stream. Intended to be fed by a UART/SPI byte receiver or the Wishbone shim.

Parameters:
ADDRESS_WIDTH, 5, RAM address width; must be 1..8 (one address byte).
DATA_WIDTH, 32, RAM word width; must be a multiple of 8; BYTES = DATA_WIDTH/8 (localparam).

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_ni  input  1  asynchronous active-low reset
rx_data_i  input  8  command/payload byte
rx_valid_i  input  1  rx byte valid
rx_ready_o  output  1  bridge can accept rx byte
tx_data_o  output  8  response byte
tx_valid_o  output  1  response byte valid
tx_ready_i  input  1  downstream accepts tx byte
ram_address_o  output  ADDRESS_WIDTH  to RAM address_i
ram_data_o  output  DATA_WIDTH  to RAM data_i
ram_we_o  output  1  to RAM we_i
ram_data_i  input  DATA_WIDTH  from RAM data_o
busy_o  output  1  high in any state other than IDLE
err_o  output  1  one-cycle pulse on unknown opcode

Behaviour:
- Reset: all state to IDLE; rx_ready_o=1 after reset release (0 during reset), tx_valid_o=0, tx_data_o=0, ram_we_o=0, ram_address_o=0, ram_data_o=0, busy_o=0, err_o=0. Reset mid-command discards partial command; no RAM write issued.
- Handshake: byte transferred on a rising edge with valid&&ready. tx_data_o stable while tx_valid_o=1 && tx_ready_i=0. rx_ready_o=1 only in IDLE, ADDR, WDATA.
- Opcodes: 0x01 WRITE = opcode, address byte, BYTES data bytes (MSB first). 0x02 READ = opcode, address byte; response = BYTES bytes MSB first. Address byte: low ADDRESS_WIDTH bits used, upper bits ignored.
- States:
  IDLE: accept opcode. 0x01 or 0x02 -> ADDR (latch op). Any other -> err_o=1 next cycle, stay IDLE.
  ADDR: accept byte -> latch address; WRITE op -> WDATA with byte counter=0; READ op -> RD_ISSUE.
  WDATA: shift each byte into the word register; after BYTES-th byte -> WRITE.
  WRITE: exactly one cycle ram_we_o=1 with ram_address_o/ram_data_o valid -> IDLE.
  RD_ISSUE: ram_we_o=0, ram_address_o=address; RAM registers the word at this edge -> RD_CAPTURE.
  RD_CAPTURE: capture ram_data_i into the tx shift register -> TX.
  TX: present bytes MSB first; advance on each tx handshake; after BYTES-th handshake tx_valid_o=0 -> IDLE.
- ram_we_o is 0 in every state except WRITE. ram_address_o/ram_data_o hold their last values otherwise.
- Latency: last WRITE byte accepted at edge N -> ram_we_o high in cycle N+1 only. Address byte of READ accepted at edge N -> tx_valid_o first asserted in cycle N+3.
- No pipelining: a new command is accepted only in IDLE. tx_ready_i is ignored outside TX.

Optional Feature:
RAM_HOST_BRIDGE_AUTOINC_EN: when defined, the address register increments modulo 2^ADDRESS_WIDTH after every completed WRITE cycle and every RD_CAPTURE. Opcodes 0x11 (WRITE, no address byte, IDLE -> WDATA) and 0x12 (READ, no address byte, IDLE -> RD_ISSUE) use the retained address. The address resets to 0. When not defined, the address is not incremented, and 0x11/0x12 are unknown opcodes (err_o pulse).

Test Plan:
- Write 0x01,0x03,0xDE,0xAD,0xBE,0xEF -> single-cycle ram_we_o=1 with ram_address_o=3 and ram_data_o=0xDEADBEEF; then 0x02,0x03 -> tx bytes 0xDE,0xAD,0xBE,0xEF, first tx_valid_o 3 cycles after the address byte is accepted.
- Address masking: write 0x01,0xE7,0x00,0x00,0x00,0x5A -> RAM write at address 7; read 0x02,0x07 -> 0x00,0x00,0x00,0x5A.
- TX backpressure: during a read, hold tx_ready_i=0 for 10 cycles -> tx_valid_o stays 1, tx_data_o stays 0xDE, rx_ready_o=0, busy_o=1; then release -> all 4 bytes delivered in order.
- Unknown opcode 0x7F -> err_o high for exactly 1 cycle, no RAM write, next 0x02,0x00 is processed normally.
- rst_ni low after 2 of 4 data bytes of a WRITE -> no ram_we_o pulse, outputs at reset values, and a fresh command works after release.
- AUTOINC_EN: 0x01,0x1F,+4 bytes then 0x11,+4 bytes -> writes at addresses 31 then 0 (wrap); without the macro, 0x11 -> err_o pulse.
